spi_slave: RTL and testbench

SPI peripheral-side endpoint for the FPGA, the counterpart of the team's SPI master. Oversamples `spi_clk`, `spi_cs_n` and `spi_mosi` in the system clock domain, deserialises MOSI bytes MSB-first, and serialises a user-supplied byte onto MISO. It sits between the board SPI pins and internal register or command logic, and uses the same byte-tick user handshake as the master.

---
 rtl/spi_slave.sv | 102 ++++++++++
 tb/tb_spi_slave.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: SPI mode 0-3 peripheral; spi_clk/spi_cs_n/spi_mosi in, spi_miso out; rx_byte/rx_tick out, tx_byte/tx_tick/tx_ready user side, busy=cs active; SPI_SLAVE_UNDERRUN_EN adds tx_underrun
module spi_slave #(
  parameter int SPI_MODE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_byte,
  input  logic       tx_tick,
  output logic       tx_ready,
  output logic [7:0] rx_byte,
  output logic       rx_tick,
  output logic       busy,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso
`ifdef SPI_SLAVE_UNDERRUN_EN
  ,
  output logic       tx_underrun
`endif
);
  localparam logic CPOL = (SPI_MODE == 2 || SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1 || SPI_MODE == 3);
  logic [2:0] clk_s, cs_s;
  logic [1:0] mosi_s;
  logic       sample_q, shift_q, csfall_q, mosi_q;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [7:0] tx_sr, hold, load_val, rx_next;
  logic       hold_full, lead, trail, load;
  always_comb begin
    lead     = ~cs_s[1] & (clk_s[1] != CPOL) & (clk_s[2] == CPOL);
    trail    = ~cs_s[1] & (clk_s[1] == CPOL) & (clk_s[2] != CPOL);
    load_val = hold_full ? hold : 8'hFF;
    load     = (csfall_q & ~CPHA) | (shift_q & (bit_cnt == 3'd0));
    rx_next  = {rx_sr, mosi_q};
  end
  assign tx_ready = ~hold_full;
  assign busy     = ~cs_s[1];
  assign spi_miso = tx_sr[7];
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s     <= {3{CPOL}};
      cs_s      <= 3'b111;
      mosi_s    <= 2'b00;
      sample_q  <= 1'b0;
      shift_q   <= 1'b0;
      csfall_q  <= 1'b0;
      mosi_q    <= 1'b0;
      bit_cnt   <= 3'd0;
      rx_sr     <= 7'd0;
      tx_sr     <= 8'd0;
      hold      <= 8'd0;
      hold_full <= 1'b0;
      rx_byte   <= 8'd0;
      rx_tick   <= 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
      tx_underrun <= 1'b0;
`endif
    end else begin
      clk_s    <= {clk_s[1:0], spi_clk};
      cs_s     <= {cs_s[1:0], spi_cs_n};
      mosi_s   <= {mosi_s[0], spi_mosi};
      sample_q <= CPHA ? trail : lead;
      shift_q  <= CPHA ? lead : trail;
      csfall_q <= cs_s[2] & ~cs_s[1];
      mosi_q   <= mosi_s[1];
      rx_tick  <= 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
      tx_underrun <= 1'b0;
`endif
      if (cs_s[1]) begin
        bit_cnt <= 3'd0;
        rx_sr   <= 7'd0;
        tx_sr   <= 8'd0;
      end else begin
        if (sample_q) begin
          rx_sr   <= rx_next[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_byte <= rx_next;
            rx_tick <= 1'b1;
          end
        end
        if (load) begin
          tx_sr     <= load_val;
          hold_full <= 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
          tx_underrun <= ~hold_full;
`endif
        end else if (shift_q) begin
          tx_sr <= {tx_sr[6:0], 1'b0};
        end
      end
      // a tick accepted alongside a load lands after the load empties the register
      if (tx_tick && !hold_full) begin
        hold      <= tx_byte;
        hold_full <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: scoreboard bench driving one spi_slave per SPI mode
module tb_spi_slave;
  localparam int H = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] tx_byte = 8'd0;
  logic [3:0] tx_tick = 4'd0;
  logic [3:0] sclk = 4'b1100;
  logic [3:0] cs_n = 4'hF;
  logic [3:0] mosi = 4'd0;
  logic [3:0] tx_ready, rx_tick, busy, miso, und;
  logic [3:0][7:0] rx_byte;
  int checks = 0;
  int errors = 0;
  int und_cnt = 0;
  logic [9:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] act_tx[$];
  logic [7:0] r;
  always #5 clk = ~clk;
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : gen_dut
      spi_slave #(.SPI_MODE(g)) dut (
        .clk(clk),
        .reset(reset),
        .tx_byte(tx_byte),
        .tx_tick(tx_tick[g]),
        .tx_ready(tx_ready[g]),
        .rx_byte(rx_byte[g]),
        .rx_tick(rx_tick[g]),
        .busy(busy[g]),
        .spi_clk(sclk[g]),
        .spi_cs_n(cs_n[g]),
        .spi_mosi(mosi[g]),
        .spi_miso(miso[g])
`ifdef SPI_SLAVE_UNDERRUN_EN
        ,
        .tx_underrun(und[g])
`endif
      );
    end
  endgenerate
`ifndef SPI_SLAVE_UNDERRUN_EN
  assign und = 4'd0;
`endif
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rx_tick[m]) begin
        if (exp_rx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: mode %0d got %0h expected none", m, rx_byte[m]);
        end else check("rx_byte", {22'd0, m[1:0], rx_byte[m]}, {22'd0, exp_rx.pop_front()});
      end
      if (und[m]) und_cnt++;
    end
    if (act_tx.size() > 0) begin
      if (exp_tx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL miso_unexpected: got %0h expected none", act_tx.pop_front());
      end else check("miso_byte", {24'd0, act_tx.pop_front()}, {24'd0, exp_tx.pop_front()});
    end
  end
  task automatic tick(input int m, input logic [7:0] b);
    @(negedge clk);
    tx_byte = b;
    tx_tick[m] = 1'b1;
    @(negedge clk);
    tx_tick[m] = 1'b0;
  endtask
  task automatic cs(input int m, input logic v);
    @(negedge clk);
    cs_n[m] = v;
    repeat (H) @(negedge clk);
  endtask
  task automatic xfer(input int m, input logic [7:0] d, input int n, output logic [7:0] rd);
    logic cpol = m[1];
    logic cpha = m[0];
    rd = 8'd0;
    for (int i = 7; i > 7 - n; i--) begin
      if (!cpha) begin
        mosi[m] = d[i];
        repeat (H) @(negedge clk);
        sclk[m] = ~cpol;
        rd[i] = miso[m];
        repeat (H) @(negedge clk);
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi[m] = d[i];
        repeat (H) @(negedge clk);
        sclk[m] = cpol;
        rd[i] = miso[m];
        repeat (H) @(negedge clk);
      end
    end
    repeat (H) @(negedge clk);
  endtask
  task automatic full(input int m, input logic [7:0] mo, input logic [7:0] so);
    exp_rx.push_back({m[1:0], mo});
    exp_tx.push_back(so);
    cs(m, 1'b0);
    xfer(m, mo, 8, r);
    act_tx.push_back(r);
    cs(m, 1'b1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      check("rst_tx_ready", {31'd0, tx_ready[m]}, 32'd1);
      check("rst_busy", {31'd0, busy[m]}, 32'd0);
      check("rst_miso", {31'd0, miso[m]}, 32'd0);
      check("rst_rx_byte", {24'd0, rx_byte[m]}, 32'd0);
    end
    reset = 1'b0;
    repeat (H) @(negedge clk);
    tick(0, 8'hA5);
    check("tx_ready_low", {31'd0, tx_ready[0]}, 32'd0);
    full(0, 8'h3C, 8'hA5);
    check("tx_ready_back", {31'd0, tx_ready[0]}, 32'd1);
    for (int m = 1; m < 4; m++) begin
      tick(m, 8'h69);
      full(m, 8'h96, 8'h69);
    end
    tick(0, 8'h11);
    exp_rx.push_back({2'd0, 8'hA1});
    exp_rx.push_back({2'd0, 8'hB2});
    exp_tx.push_back(8'h11);
    exp_tx.push_back(8'h22);
    cs(0, 1'b0);
    begin
      int k = 0;
      while (!tx_ready[0] && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("b2b_tx_ready_rise", {31'd0, tx_ready[0]}, 32'd1);
    end
    tick(0, 8'h22);
    xfer(0, 8'hA1, 8, r);
    act_tx.push_back(r);
    xfer(0, 8'hB2, 8, r);
    act_tx.push_back(r);
    cs(0, 1'b1);
    repeat (H) @(negedge clk);
    und_cnt = 0;
    full(1, 8'h5E, 8'hFF);
`ifdef SPI_SLAVE_UNDERRUN_EN
    check("underrun_count", und_cnt, 32'd1);
`endif
    cs(0, 1'b0);
    xfer(0, 8'hFF, 5, r);
    cs(0, 1'b1);
    full(0, 8'hC3, 8'hFF);
    tick(0, 8'h77);
    cs(0, 1'b0);
    xfer(0, 8'h0F, 4, r);
    @(negedge clk);
    reset = 1'b1;
    cs_n[0] = 1'b1;
    sclk[0] = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_tx_ready", {31'd0, tx_ready[0]}, 32'd1);
    check("mid_rst_rx_byte", {24'd0, rx_byte[0]}, 32'd0);
    check("mid_rst_rx_tick", {31'd0, rx_tick[0]}, 32'd0);
    check("mid_rst_busy", {31'd0, busy[0]}, 32'd0);
    check("mid_rst_miso", {31'd0, miso[0]}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (H) @(negedge clk);
    tick(0, 8'hE7);
    full(0, 8'h5A, 8'hE7);
    repeat (20) @(negedge clk);
    check("rx_queue_empty", exp_rx.size(), 32'd0);
    check("tx_queue_empty", exp_tx.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
